// File: rtl/adc_tx_pkg.sv
// rtl/adc_tx_pkg.sv - shared mode and state encodings for the serial ADC emulator
package adc_tx_pkg;
  localparam logic [1:0] MODE_EXT  = 2'b00;
  localparam logic [1:0] MODE_RAMP = 2'b01;
  localparam logic [1:0] MODE_PAT  = 2'b10;
  localparam logic [1:0] MODE_ALT  = 2'b11;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;
endpackage

// File: rtl/adc_word_source.sv
// rtl/adc_word_source.sv - picks the next sample word and advances ramp/alternate state at each load
module adc_word_source
  import adc_tx_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             from_idle,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_ready,
  output logic             underrun
);
  logic [WIDTH-1:0] ramp;
  logic             alt_phase;
  logic             alt_now;

  // A fresh stream always opens with the true pattern, whatever phase was left over.
  assign alt_now    = alt_phase & ~from_idle;
  assign word_ready = advance & (mode == MODE_EXT);

  always_comb begin
    word = '0;
    case (mode)
      MODE_EXT:  word = word_valid ? word_in : '0;
      MODE_RAMP: word = ramp;
      MODE_PAT:  word = pattern;
      default:   word = alt_now ? ~pattern : pattern;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp      <= '0;
      alt_phase <= 1'b0;
      underrun  <= 1'b0;
    end else if (advance) begin
      if (mode == MODE_RAMP) ramp <= ramp + WIDTH'(1);
      alt_phase <= (mode == MODE_ALT) ? ~alt_now : 1'b0;
      if ((mode == MODE_EXT) && !word_valid) underrun <= 1'b1;
    end
  end
endmodule

// File: rtl/adc_lvds_transmitter.sv
// rtl/adc_lvds_transmitter.sv - serializes sample words MSB-first with frame strobe and data-ready
module adc_lvds_transmitter
  import adc_tx_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int FRAME_HIGH = 6,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             adc_data_p,
  output logic             adc_frame,
  output logic             adc_data_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             underrun
);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [BW-1:0] FRAME_END = BW'(FRAME_HIGH);

  logic             state, state_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] src_word;
  logic             load;

  assign load = enable & ((state == IDLE) | (bit_cnt == LAST_BIT));

  adc_word_source #(.WIDTH(WIDTH)) u_source (
    .clk        (clk),
    .reset      (reset),
    .advance    (load),
    .from_idle  (state == IDLE),
    .mode       (mode),
    .pattern    (pattern),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word       (src_word),
    .word_ready (word_ready),
    .underrun   (underrun)
  );

  // Leaving SHIFT clears the shifter so the line idles low after the LSB.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    sreg_n    = sreg;
    if (load) begin
      state_n   = SHIFT;
      bit_cnt_n = '0;
      sreg_n    = src_word;
    end else if (state == SHIFT) begin
      if (bit_cnt == LAST_BIT) begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        sreg_n    = '0;
      end else begin
        bit_cnt_n = bit_cnt + BW'(1);
        sreg_n    = {sreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      sreg           <= '0;
      adc_data_p     <= 1'b0;
      adc_frame      <= 1'b0;
      adc_data_ready <= 1'b0;
      word_count     <= '0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      sreg           <= sreg_n;
      adc_data_p     <= sreg_n[WIDTH-1];
      adc_frame      <= (state_n == SHIFT) && (bit_cnt_n < FRAME_END);
      adc_data_ready <= (state_n == SHIFT);
      word_count     <= word_count + CNT_W'(load);
    end
  end
endmodule

// File: tb/tb_adc_lvds_transmitter.sv
// tb/tb_adc_lvds_transmitter.sv - scoreboard bench deserializing the link and checking words and strobes
module tb_adc_lvds_transmitter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] pattern = '0;
  logic [11:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready, adc_data_p, adc_frame, adc_data_ready, underrun;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_pass = 0;
  logic [11:0] exp_q[$];
  int bitpos = 0;
  int ready_pulses = 0;
  int ready_cycles = 0;
  logic [11:0] dbits, fbits, e;
  int rp0, rc0;

  adc_lvds_transmitter dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .pattern(pattern),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .adc_data_p(adc_data_p), .adc_frame(adc_frame), .adc_data_ready(adc_data_ready),
    .word_count(word_count), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Receiver model: collect WIDTH bits per word while data-ready is high.
  always @(negedge clk) begin
    if (reset) begin
      bitpos = 0;
    end else begin
      if (word_ready) ready_pulses++;
      if (adc_data_ready) begin
        ready_cycles++;
        dbits = {dbits[10:0], adc_data_p};
        fbits = {fbits[10:0], adc_frame};
        bitpos++;
        if (bitpos == 12) begin
          if (exp_q.size() == 0) chk("unexpected_word", 32'(dbits), 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("word", 32'(dbits), 32'(e));
            chk("frame_shape", 32'(fbits), 32'hFC0);
          end
          bitpos = 0;
        end
      end else if (bitpos != 0) begin
        chk("truncated_word", 32'(bitpos), 32'd0);
        bitpos = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && adc_data_ready; i++) tick();
    chk("idle_ready", 32'(adc_data_ready), 32'd0);
    chk("idle_data", 32'(adc_data_p), 32'd0);
    chk("idle_frame", 32'(adc_frame), 32'd0);
  endtask

  task automatic run(input int n);
    enable = 1'b1;
    repeat (12 * n - 7) tick();
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_data", 32'(adc_data_p), 32'd0);
    chk("rst_frame", 32'(adc_frame), 32'd0);
    chk("rst_ready", 32'(adc_data_ready), 32'd0);
    chk("rst_word_ready", 32'(word_ready), 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    tick();

    // ramp, three words
    mode = 2'b01;
    exp_q.push_back(12'h000); exp_q.push_back(12'h001); exp_q.push_back(12'h002);
    rc0 = ready_cycles;
    run(3);
    chk("ramp_ready_cycles", 32'(ready_cycles - rc0), 32'd36);
    chk("count_after_ramp", 32'(word_count), 32'd3);

    // external words, latency and word_ready pulses
    mode = 2'b00; word_in = 12'hA5C; word_valid = 1'b1; enable = 1'b1;
    rp0 = ready_pulses;
    exp_q.push_back(12'hA5C); exp_q.push_back(12'h3C1);
    #1;
    chk("word_ready_at_load", 32'(word_ready), 32'd1);
    chk("ready_before_load", 32'(adc_data_ready), 32'd0);
    tick();
    chk("latency_ready", 32'(adc_data_ready), 32'd1);
    chk("latency_msb", 32'(adc_data_p), 32'd1);
    word_in = 12'h3C1;
    repeat (12 * 2 - 7 - 1) tick();
    enable = 1'b0; word_valid = 1'b0;
    wait_idle();
    chk("word_ready_pulses", 32'(ready_pulses - rp0), 32'd2);
    chk("no_underrun", 32'(underrun), 32'd0);
    chk("count_after_ext", 32'(word_count), 32'd5);

    // missing external word
    word_in = 12'hA5C; word_valid = 1'b1; enable = 1'b1;
    exp_q.push_back(12'hA5C); exp_q.push_back(12'h000); exp_q.push_back(12'h123);
    tick();
    word_valid = 1'b0;
    repeat (12) tick();
    chk("underrun_set", 32'(underrun), 32'd1);
    word_in = 12'h123; word_valid = 1'b1;
    repeat (12 * 3 - 7 - 13) tick();
    enable = 1'b0; word_valid = 1'b0;
    wait_idle();
    chk("underrun_sticky", 32'(underrun), 32'd1);
    chk("count_after_underrun", 32'(word_count), 32'd8);

    // alternate pattern with mid-word mode/pattern disturbance
    mode = 2'b11; pattern = 12'h9FF; enable = 1'b1;
    exp_q.push_back(12'h9FF); exp_q.push_back(12'h600); exp_q.push_back(12'h9FF);
    repeat (4) tick();
    mode = 2'b00; pattern = 12'h123;
    repeat (3) tick();
    mode = 2'b11; pattern = 12'h9FF;
    repeat (12 * 3 - 7 - 7) tick();
    enable = 1'b0;
    wait_idle();
    exp_q.push_back(12'h9FF);
    run(1);
    mode = 2'b10; pattern = 12'h5A3;
    exp_q.push_back(12'h5A3); exp_q.push_back(12'h5A3);
    run(2);
    chk("count_after_pattern", 32'(word_count), 32'd14);

    // asynchronous reset mid-word
    mode = 2'b01; enable = 1'b1;
    repeat (8) tick();
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_data", 32'(adc_data_p), 32'd0);
    chk("arst_frame", 32'(adc_frame), 32'd0);
    chk("arst_ready", 32'(adc_data_ready), 32'd0);
    chk("arst_count", 32'(word_count), 32'd0);
    chk("arst_underrun", 32'(underrun), 32'd0);
    enable = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(12'h000);
    run(1);
    chk("count_after_restart", 32'(word_count), 32'd1);

    // ramp through 0xFFF and wrap
    for (int i = 0; i < 4097; i++) exp_q.push_back(12'((i + 1) & 12'hFFF));
    run(4097);
    chk("count_after_wrap", 32'(word_count), 32'd4098);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
